hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised pipeline hazard and control unit for the 5-stage (IF/ID/EX/MEM/WB) core. It keeps its own shadow pipeline of destination-register tags for EX, MEM and WB. From these tags it produces forwarding selects, load-use stalls, branch flushes and whole-pipeline freezes on bus wait states. It also keeps performance counters. It sits beside the stage registers and drives their hold/flush/bubble controls and the ID-stage operand muxes.

## Interface
- `RW`, 5: register-address width; register 0 is hardwired zero.
- `FWD_EN`, 1: 1 = full forwarding with load-use stall; 0 = no forwarding, stall on any pending writer.
- `CNT_W`, 32: performance-counter width.
- `cpu_clk` input 1: clock, rising edge.
- `cpu_rst` input 1: reset, asynchronous, active-low.
- `id_valid` input 1: ID stage holds a real instruction.
- `id_rs1`, `id_rs2` input RW each: ID source registers.
- `id_re` input 2: bit0 = rs1 read, bit1 = rs2 read.
- `id_rd` input RW: ID destination register.
- `id_we` input 1: ID instruction writes the register file.
- `id_is_load` input 1: ID instruction is a load.
- `ex_redirect` input 1: EX resolved a taken branch or jump.
- `mem_busy` input 1: bus not ready; the whole pipeline must freeze.
- `cnt_clr` input 1: synchronous clear of all counters.
- `pc_hold` output 1: PC keeps its value.
- `ifid_hold` output 1: IF_ID keeps its value.
- `ifid_flush` output 1: IF_ID loads a bubble.
- `idex_bubble` output 1: ID_EX loads a bubble.
- `pipe_freeze` output 1: ID_EX, EX_MEM and MEM_WB keep their values.
- `fwd_sel1`, `fwd_sel2` output 2: operand source; 0 = RF, 1 = EX ALU result, 2 = MEM result, 3 = WB write data.
- `cyc_cnt`, `stall_cnt`, `flush_cnt`, `retire_cnt` output CNT_W each: performance counters.

## Operation
- Tag pipeline: three entries, `ex`, `mem`, `wb`. Each entry holds {valid, rd, we, is_load}. An entry's `we` is forced to 0 when its rd = 0.
- Advance happens on every edge where mem_busy = 0:
  - `wb` ← `mem`, and `mem` ← `ex`.
  - `ex` ← ID fields when no stall and no flush; otherwise `ex` ← bubble (all zero).
  - When mem_busy = 1, all tags hold.
- Match rule: source n matches an entry when id_re[n] = 1, id_valid = 1, the entry is valid with we = 1, and entry.rd = rs_n ≠ 0.
- FWD_EN = 1:
  - fwd_sel picks the youngest matching entry; priority EX > MEM > WB, and 0 if there is no match.
  - Load-use stall: a source matches the `ex` entry and that entry has is_load = 1.
- FWD_EN = 0:
  - fwd_sel is constant 0.
  - Stall: any source matches any of `ex`, `mem` or `wb`.
- flush = ex_redirect and not mem_busy. stall_q = hazard stall and not flush; a redirect overrides the stall because the ID instruction is killed.
- Output equations:
  - pipe_freeze = mem_busy.
  - pc_hold = mem_busy or stall_q.
  - ifid_hold = mem_busy or stall_q.
  - ifid_flush = flush.
  - idex_bubble = not mem_busy and (stall_q or flush).
- Redirect during mem_busy is ignored. EX is frozen, so ex_redirect stays asserted and takes effect on the first non-busy cycle.
- Counters, each modulo 2^CNT_W:
  - cyc_cnt increments every cycle.
  - stall_cnt increments on cycles with stall_q = 1.
  - flush_cnt increments on cycles with flush = 1.
  - retire_cnt increments on cycles where `wb` is valid and mem_busy = 0.
  - cnt_clr = 1 zeroes all four on the next edge and has priority over increment.

## Timing
- Reset (cpu_rst = 0, asynchronous): all tags invalid and all counters 0. As a result every output is 0: no holds, no flush, fwd_sel = 0.
- All control outputs and fwd_sel are combinational from the current tags and inputs, valid in the same cycle. Tags and counters update on the rising edge.
- Load-use with FWD_EN = 1: exactly one stall cycle. On the next cycle the load is in `mem`, and fwd_sel = 2.
- FWD_EN = 0: a dependent instruction stalls until its writer has left `wb`; that is 3 cycles behind an adjacent writer.
- Reset mid-stall or mid-freeze: everything clears immediately, with no residual hold.

## Test plan
- FWD_EN = 1; `add x5` in EX; ID reads rs1 = x5 → fwd_sel1 = 1, no stall. One cycle later (writer in MEM) → fwd_sel1 = 2. Next cycle → 3.
- FWD_EN = 1; `lw x6` in EX; ID reads rs2 = x6 → pc_hold = ifid_hold = idex_bubble = 1 for 1 cycle. Next cycle fwd_sel2 = 2, and stall_cnt = 1.
- Writer with rd = x0 in EX; ID reads x0 → fwd_sel = 0, no stall.
- Load-use hazard and ex_redirect in the same cycle → ifid_flush = idex_bubble = 1, pc_hold = 0, flush_cnt +1, stall_cnt unchanged.
- mem_busy held 4 cycles with ex_redirect = 1 → pipe_freeze = 1, no flush, tags frozen, retire_cnt unchanged, cyc_cnt +4. Flush happens on the 5th cycle.
- FWD_EN = 0; `add x7` then a dependent reader → exactly 3 stall cycles. After these, fwd_sel = 0 throughout. Async reset asserted mid-stall → all outputs 0 immediately.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/control unit: shadow destination-tag pipeline (EX/MEM/WB), operand
// forwarding selects, load-use and no-forwarding stalls, redirect flushes, bus freezes, perf counters.
module hazard_ctrl #(
    parameter int RW     = 5,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 32
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst,
    input  logic             id_valid,
    input  logic [RW-1:0]    id_rs1,
    input  logic [RW-1:0]    id_rs2,
    input  logic [1:0]       id_re,
    input  logic [RW-1:0]    id_rd,
    input  logic             id_we,
    input  logic             id_is_load,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    input  logic             cnt_clr,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_freeze,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rd;
        logic          we;
    } tag_t;

    // Only the EX entry's load flag is ever consulted, so it is kept beside the tag.
    tag_t ex_q, mem_q, wb_q;
    logic ex_is_load_q;

    logic [1:0] hit_ex, hit_mem, hit_wb;
    logic       hazard, flush, stall_q;

    function automatic logic hit(input tag_t t, input logic [RW-1:0] rs,
                                 input logic re, input logic vld);
        return re && vld && t.valid && t.we && (t.rd == rs) && (rs != '0);
    endfunction

    function automatic logic [1:0] pick(input logic e, input logic m, input logic w);
        if (e)      return 2'd1;
        else if (m) return 2'd2;
        else if (w) return 2'd3;
        return 2'd0;
    endfunction

    assign hit_ex  = {hit(ex_q,  id_rs2, id_re[1], id_valid), hit(ex_q,  id_rs1, id_re[0], id_valid)};
    assign hit_mem = {hit(mem_q, id_rs2, id_re[1], id_valid), hit(mem_q, id_rs1, id_re[0], id_valid)};
    assign hit_wb  = {hit(wb_q,  id_rs2, id_re[1], id_valid), hit(wb_q,  id_rs1, id_re[0], id_valid)};

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        fwd_sel1 = 2'd0;
        fwd_sel2 = 2'd0;
        hazard   = 1'b0;
        if (FWD_EN) begin
            fwd_sel1 = pick(hit_ex[0], hit_mem[0], hit_wb[0]);
            fwd_sel2 = pick(hit_ex[1], hit_mem[1], hit_wb[1]);
            hazard   = ex_is_load_q && (|hit_ex);
        end else begin
            hazard   = (|hit_ex) || (|hit_mem) || (|hit_wb);
        end
    end

    // A redirect kills the ID instruction, so it overrides any hazard stall.
    assign flush       = ex_redirect && !mem_busy;
    assign stall_q     = hazard && !flush;
    assign pipe_freeze = mem_busy;
    assign pc_hold     = mem_busy || stall_q;
    assign ifid_hold   = mem_busy || stall_q;
    assign ifid_flush  = flush;
    assign idex_bubble = !mem_busy && (stall_q || flush);

    // NOTE: state registers use non-blocking assignments so all tags shift from pre-edge values.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            ex_q         <= '0;
            mem_q        <= '0;
            wb_q         <= '0;
            ex_is_load_q <= 1'b0;
        end else if (!mem_busy) begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            if (hazard || flush) begin
                ex_q         <= '0;
                ex_is_load_q <= 1'b0;
            end else begin
                ex_q         <= '{valid: id_valid, rd: id_rd, we: id_we && (id_rd != '0)};
                ex_is_load_q <= id_is_load;
            end
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            cyc_cnt    <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else if (cnt_clr) begin
            cyc_cnt    <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (stall_q)                  stall_cnt  <= stall_cnt + CNT_W'(1);
            if (flush)                    flush_cnt  <= flush_cnt + CNT_W'(1);
            if (wb_q.valid && !mem_busy)  retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: one forwarding and one non-forwarding instance share directed stimulus;
// an instruction-history model predicts every output each cycle, plus literal spot checks.
module tb_hazard_ctrl;

    logic       cpu_clk = 1'b0;
    logic       cpu_rst;
    logic       id_valid, id_we, id_is_load, ex_redirect, mem_busy, cnt_clr;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic [1:0] id_re;

    // Index 1 = FWD_EN=1 instance, index 0 = FWD_EN=0 instance.
    logic [1:0]  pc_hold_v, ifid_hold_v, ifid_flush_v, idex_bubble_v, pipe_freeze_v;
    logic [1:0]  fsel1_v [2];
    logic [1:0]  fsel2_v [2];
    logic [31:0] cyc_v [2];
    logic [31:0] stall_v [2];
    logic [31:0] flush_v [2];
    logic [31:0] ret_v [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 cpu_clk = ~cpu_clk;

    hazard_ctrl #(.RW(5), .FWD_EN(1'b1), .CNT_W(32)) u_fwd (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_re(id_re), .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
        .pc_hold(pc_hold_v[1]), .ifid_hold(ifid_hold_v[1]), .ifid_flush(ifid_flush_v[1]),
        .idex_bubble(idex_bubble_v[1]), .pipe_freeze(pipe_freeze_v[1]),
        .fwd_sel1(fsel1_v[1]), .fwd_sel2(fsel2_v[1]), .cyc_cnt(cyc_v[1]),
        .stall_cnt(stall_v[1]), .flush_cnt(flush_v[1]), .retire_cnt(ret_v[1]));

    hazard_ctrl #(.RW(5), .FWD_EN(1'b0), .CNT_W(32)) u_nofwd (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_re(id_re), .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load),
        .ex_redirect(ex_redirect), .mem_busy(mem_busy), .cnt_clr(cnt_clr),
        .pc_hold(pc_hold_v[0]), .ifid_hold(ifid_hold_v[0]), .ifid_flush(ifid_flush_v[0]),
        .idex_bubble(idex_bubble_v[0]), .pipe_freeze(pipe_freeze_v[0]),
        .fwd_sel1(fsel1_v[0]), .fwd_sel2(fsel2_v[0]), .cyc_cnt(cyc_v[0]),
        .stall_cnt(stall_v[0]), .flush_cnt(flush_v[0]), .retire_cnt(ret_v[0]));

    // ---------------- model: last three issued instructions per instance ----------------
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       we;
        logic       ld;
    } ent_t;

    ent_t        m_tag [2][3];   // [instance][0=EX,1=MEM,2=WB]
    logic [31:0] m_cyc [2];
    logic [31:0] m_stall [2];
    logic [31:0] m_flush [2];
    logic [31:0] m_ret [2];

    function automatic bit src_hit(int f, int k, int n);
        logic [4:0] rs;
        rs = (n == 0) ? id_rs1 : id_rs2;
        return id_valid && id_re[n] && m_tag[f][k].v && m_tag[f][k].we
               && (m_tag[f][k].rd == rs) && (rs != 5'd0);
    endfunction

    function automatic bit m_hazard(int f);
        for (int n = 0; n < 2; n++)
            for (int k = 0; k < 3; k++)
                if (src_hit(f, k, n) && (f == 0 || (k == 0 && m_tag[f][0].ld)))
                    return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] m_fsel(int f, int n);
        if (f == 0) return 2'd0;
        for (int k = 0; k < 3; k++)
            if (src_hit(f, k, n)) return 2'(k + 1);
        return 2'd0;
    endfunction

    function automatic bit m_fl();
        return ex_redirect && !mem_busy;
    endfunction

    function automatic bit m_st(int f);
        return m_hazard(f) && !m_fl();
    endfunction

    always @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            for (int f = 0; f < 2; f++) begin
                for (int k = 0; k < 3; k++) m_tag[f][k] <= '0;
                m_cyc[f]   <= '0;
                m_stall[f] <= '0;
                m_flush[f] <= '0;
                m_ret[f]   <= '0;
            end
        end else begin
            for (int f = 0; f < 2; f++) begin
                if (cnt_clr) begin
                    m_cyc[f]   <= '0;
                    m_stall[f] <= '0;
                    m_flush[f] <= '0;
                    m_ret[f]   <= '0;
                end else begin
                    m_cyc[f] <= m_cyc[f] + 1;
                    if (m_st(f))                      m_stall[f] <= m_stall[f] + 1;
                    if (m_fl())                       m_flush[f] <= m_flush[f] + 1;
                    if (m_tag[f][2].v && !mem_busy)   m_ret[f]   <= m_ret[f] + 1;
                end
                if (!mem_busy) begin
                    m_tag[f][2] <= m_tag[f][1];
                    m_tag[f][1] <= m_tag[f][0];
                    m_tag[f][0] <= (m_hazard(f) || m_fl()) ? ent_t'('0)
                                 : ent_t'{id_valid, id_rd, id_we && (id_rd != 5'd0), id_is_load};
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare(input int f);
        bit fl, st;
        fl = m_fl();
        st = m_st(f);
        check($sformatf("f%0d pipe_freeze", f), 32'(pipe_freeze_v[f]), 32'(mem_busy));
        check($sformatf("f%0d pc_hold", f),     32'(pc_hold_v[f]),     32'(mem_busy || st));
        check($sformatf("f%0d ifid_hold", f),   32'(ifid_hold_v[f]),   32'(mem_busy || st));
        check($sformatf("f%0d ifid_flush", f),  32'(ifid_flush_v[f]),  32'(fl));
        check($sformatf("f%0d idex_bubble", f), 32'(idex_bubble_v[f]), 32'(!mem_busy && (st || fl)));
        check($sformatf("f%0d fwd_sel1", f),    32'(fsel1_v[f]),       32'(m_fsel(f, 0)));
        check($sformatf("f%0d fwd_sel2", f),    32'(fsel2_v[f]),       32'(m_fsel(f, 1)));
        check($sformatf("f%0d cyc_cnt", f),     cyc_v[f],              m_cyc[f]);
        check($sformatf("f%0d stall_cnt", f),   stall_v[f],            m_stall[f]);
        check($sformatf("f%0d flush_cnt", f),   flush_v[f],            m_flush[f]);
        check($sformatf("f%0d retire_cnt", f),  ret_v[f],              m_ret[f]);
    endtask

    always @(negedge cpu_clk) begin
        compare(1);
        compare(0);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [1:0] re, input logic [4:0] rd, input logic we,
                         input logic ld);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_re = re;
        id_rd = rd; id_we = we; id_is_load = ld;
    endtask

    task automatic idle();
        issue(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        cpu_rst = 1'b1;
        idle();
        ex_redirect = 1'b0; mem_busy = 1'b0; cnt_clr = 1'b0;
        #1 cpu_rst = 1'b0;
        #2;
        check("reset pc_hold",  32'(pc_hold_v[1]), 32'd0);
        check("reset fwd_sel1", 32'(fsel1_v[1]),   32'd0);
        check("reset cyc_cnt",  cyc_v[1],          32'd0);
        #10 cpu_rst = 1'b1;
        tick();

        // Adjacent ALU writer x5 followed by a reader of x5.
        issue(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0); tick();
        issue(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0); #1;
        check("alu ex fwd_sel1",      32'(fsel1_v[1]),   32'd1);
        check("alu ex no stall",      32'(pc_hold_v[1]), 32'd0);
        check("nofwd stall c1",       32'(pc_hold_v[0]), 32'd1);
        check("nofwd fwd_sel1 0",     32'(fsel1_v[0]),   32'd0);
        tick(); #1;
        check("alu mem fwd_sel1",     32'(fsel1_v[1]),   32'd2);
        check("nofwd stall c2",       32'(pc_hold_v[0]), 32'd1);
        tick(); #1;
        check("alu wb fwd_sel1",      32'(fsel1_v[1]),   32'd3);
        check("nofwd stall c3",       32'(pc_hold_v[0]), 32'd1);
        tick(); #1;
        check("alu gone fwd_sel1",    32'(fsel1_v[1]),   32'd0);
        check("nofwd released",       32'(pc_hold_v[0]), 32'd0);
        check("nofwd three stalls",   stall_v[0],        32'd3);
        tick();

        // Load-use: lw x6 then reader of x6 on rs2.
        idle(); cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        issue(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b1); tick();
        issue(1'b1, 5'd0, 5'd6, 2'b10, 5'd0, 1'b0, 1'b0); #1;
        check("ld-use pc_hold",       32'(pc_hold_v[1]),     32'd1);
        check("ld-use ifid_hold",     32'(ifid_hold_v[1]),   32'd1);
        check("ld-use idex_bubble",   32'(idex_bubble_v[1]), 32'd1);
        tick(); #1;
        check("ld-use after fwd2",    32'(fsel2_v[1]),   32'd2);
        check("ld-use after no hold", 32'(pc_hold_v[1]), 32'd0);
        check("ld-use stall_cnt",     stall_v[1],        32'd1);
        check("ld-use cyc_cnt",       cyc_v[1],          32'd2);
        tick(); #1;
        check("ld wb fwd2",           32'(fsel2_v[1]),   32'd3);
        tick(); #1;
        check("nofwd ld released",    32'(pc_hold_v[0]), 32'd0);
        check("nofwd ld stall_cnt",   stall_v[0],        32'd3);
        tick();

        // Writer to x0 and reader of x0.
        issue(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0); tick();
        issue(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 1'b0, 1'b0); #1;
        check("x0 fwd_sel1",          32'(fsel1_v[1]),   32'd0);
        check("x0 fwd_sel2",          32'(fsel2_v[1]),   32'd0);
        check("x0 no stall",          32'(pc_hold_v[1]), 32'd0);
        check("x0 nofwd no stall",    32'(pc_hold_v[0]), 32'd0);
        tick();

        // Load-use hazard coinciding with a redirect.
        idle(); cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        issue(1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 1'b1); tick();
        issue(1'b1, 5'd8, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0); ex_redirect = 1'b1; #1;
        check("redir ifid_flush",     32'(ifid_flush_v[1]),  32'd1);
        check("redir idex_bubble",    32'(idex_bubble_v[1]), 32'd1);
        check("redir pc_hold",        32'(pc_hold_v[1]),     32'd0);
        tick();
        ex_redirect = 1'b0; idle(); #1;
        check("redir flush_cnt",      flush_v[1], 32'd1);
        check("redir stall_cnt",      stall_v[1], 32'd0);
        tick();

        // Four busy cycles with a pending redirect, writers in flight.
        idle(); tick(); tick();
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        for (int r = 9; r <= 12; r++) begin
            issue(1'b1, 5'd0, 5'd0, 2'b00, 5'(r), 1'b1, 1'b0);
            tick();
        end
        issue(1'b1, 5'd11, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0);
        mem_busy = 1'b1; ex_redirect = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("busy pipe_freeze",     32'(pipe_freeze_v[1]), 32'd1);
            check("busy no flush",        32'(ifid_flush_v[1]),  32'd0);
            check("busy tags frozen",     32'(fsel1_v[1]),       32'd2);
            tick();
        end
        mem_busy = 1'b0; #1;
        check("post-busy flush",      32'(ifid_flush_v[1]), 32'd1);
        check("busy retire_cnt",      ret_v[1],             32'd1);
        check("busy cyc_cnt",         cyc_v[1],             32'd8);
        tick();
        ex_redirect = 1'b0;

        // Async reset in the middle of a no-forwarding stall.
        issue(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0); tick();
        issue(1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0); #1;
        check("pre-reset stall",      32'(pc_hold_v[0]), 32'd1);
        #2 cpu_rst = 1'b0;
        #1;
        check("mid-stall rst pc_hold",     32'(pc_hold_v[0]),     32'd0);
        check("mid-stall rst ifid_hold",   32'(ifid_hold_v[0]),   32'd0);
        check("mid-stall rst idex_bubble", 32'(idex_bubble_v[0]), 32'd0);
        check("mid-stall rst stall_cnt",   stall_v[0],            32'd0);
        check("mid-stall rst fwd_sel1",    32'(fsel1_v[1]),       32'd0);
        #3 cpu_rst = 1'b1;
        idle();
        tick(); tick(); tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
